// File: rtl/vram_blit_copy_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vram_blit_copy_pkg
// Description : Shared VRAM types plus the blitter mode and state encodings
//               used by the blitter-side VRAM requester.
// Revision    : 1.0 - initial release
// ============================================================================
package vram_blit_copy_pkg;

    localparam int ADDR_W = 16;
    localparam int WORD_W = 16;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic {
        BLIT_FILL = 1'b0,
        BLIT_COPY = 1'b1
    } blit_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } blit_state_t;

endpackage : vram_blit_copy_pkg
`default_nettype wire

// File: rtl/vram_blit_copy.sv
`default_nettype none
// ============================================================================
// Module      : vram_blit_copy
// Description : Blitter-side VRAM requester. Performs a linear FILL (write a
//               constant word N times) or COPY (read src, write dst, N times)
//               with ascending addresses through the arbiter's lowest-priority
//               port. Each access is held until the arbiter acks it.
// Ports       : clk, reset_ni            - clock, async active-low reset
//               start_i .. wr_mask_i     - operation parameters, latched on an
//                                          accepted start in IDLE
//               busy_o, done_o           - status / one-cycle completion pulse
//               blit_sel_o .. blit_data_o- registered request to the arbiter
//               blit_ack_i, vram_data_i  - arbiter ack and shared read data
// Revision    : 1.0 - initial release
// ============================================================================
module vram_blit_copy
    import vram_blit_copy_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset_ni,
    input  logic               start_i,
    input  logic               mode_i,
    input  addr_t              src_addr_i,
    input  addr_t              dst_addr_i,
    input  logic [COUNT_W-1:0] count_i,
    input  word_t              fill_data_i,
    input  logic [3:0]         wr_mask_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               blit_sel_o,
    output logic               blit_wr_o,
    output logic [3:0]         blit_wr_mask_o,
    output addr_t              blit_addr_o,
    output word_t              blit_data_o,
    input  logic               blit_ack_i,
    input  word_t              vram_data_i
);

    localparam logic [COUNT_W-1:0] c_one = COUNT_W'(1);

    blit_state_t        r_state;
    blit_mode_t         r_mode;
    addr_t              r_src;        // next source address to read
    addr_t              r_dst;        // address of the current/next write
    logic [COUNT_W-1:0] r_remaining;  // words still to be written
    logic [3:0]         r_mask;

    logic               r_busy;
    logic               r_done;
    logic               r_sel;
    logic               r_wr;
    logic [3:0]         r_wr_mask;
    addr_t              r_addr;
    word_t              r_data;

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state     <= ST_IDLE;
            r_mode      <= BLIT_FILL;
            r_src       <= '0;
            r_dst       <= '0;
            r_remaining <= '0;
            r_mask      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_sel       <= 1'b0;
            r_wr        <= 1'b0;
            r_wr_mask   <= '0;
            r_addr      <= '0;
            r_data      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_mode      <= blit_mode_t'(mode_i);
                        r_src       <= src_addr_i;
                        r_dst       <= dst_addr_i;
                        r_remaining <= count_i;
                        r_mask      <= wr_mask_i;
                        if (count_i == '0) begin
                            // Zero-length operation completes without touching VRAM.
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else if (blit_mode_t'(mode_i) == BLIT_COPY) begin
                            r_state   <= ST_READ;
                            r_busy    <= 1'b1;
                            r_sel     <= 1'b1;
                            r_wr      <= 1'b0;
                            r_wr_mask <= '0;
                            r_addr    <= src_addr_i;
                        end else begin
                            r_state   <= ST_WRITE;
                            r_busy    <= 1'b1;
                            r_sel     <= 1'b1;
                            r_wr      <= 1'b1;
                            r_wr_mask <= wr_mask_i;
                            r_addr    <= dst_addr_i;
                            r_data    <= fill_data_i;
                        end
                    end
                end

                ST_READ: begin
                    // Request is held unchanged until the arbiter acks it; the
                    // next request goes out the cycle after the ack.
                    if (blit_ack_i) begin
                        r_data    <= vram_data_i;
                        r_src     <= r_src + addr_t'(1);
                        r_state   <= ST_WRITE;
                        r_wr      <= 1'b1;
                        r_wr_mask <= r_mask;
                        r_addr    <= r_dst;
                    end
                end

                ST_WRITE: begin
                    if (blit_ack_i) begin
                        r_dst       <= r_dst + addr_t'(1);
                        r_remaining <= r_remaining - c_one;
                        if (r_remaining == c_one) begin
                            r_state   <= ST_DONE;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_sel     <= 1'b0;
                            r_wr      <= 1'b0;
                            r_wr_mask <= '0;
                        end else if (r_mode == BLIT_COPY) begin
                            // r_src already points past the word just written.
                            r_state   <= ST_READ;
                            r_wr      <= 1'b0;
                            r_wr_mask <= '0;
                            r_addr    <= r_src;
                        end else begin
                            // FILL keeps the same data word; only the address moves.
                            r_addr <= r_dst + addr_t'(1);
                        end
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o         = r_busy;
    assign done_o         = r_done;
    assign blit_sel_o     = r_sel;
    assign blit_wr_o      = r_wr;
    assign blit_wr_mask_o = r_wr_mask;
    assign blit_addr_o    = r_addr;
    assign blit_data_o    = r_data;

endmodule : vram_blit_copy
`default_nettype wire

// File: tb/tb_vram_blit_copy.sv
`default_nettype none
// ============================================================================
// Module      : tb_vram_blit_copy
// Description : Self-checking bench for vram_blit_copy. A small behavioural
//               arbiter/VRAM model grants the blitter when no higher-priority
//               request (vgen_sel) is active, acks one cycle after the grant,
//               and applies nibble-masked writes to a 64K-word memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_blit_copy;
    import vram_blit_copy_pkg::*;

    logic        clk = 1'b0;
    logic        reset_ni;
    logic        start_i;
    logic        mode_i;
    addr_t       src_addr_i;
    addr_t       dst_addr_i;
    logic [15:0] count_i;
    word_t       fill_data_i;
    logic [3:0]  wr_mask_i;
    logic        busy_o;
    logic        done_o;
    logic        blit_sel_o;
    logic        blit_wr_o;
    logic [3:0]  blit_wr_mask_o;
    addr_t       blit_addr_o;
    word_t       blit_data_o;
    logic        blit_ack_i;
    word_t       vram_data_i;

    logic        arb_ack;
    logic        stale_ack;
    logic        vgen_sel;
    word_t       mem [0:65535];
    int          grants;

    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign blit_ack_i = arb_ack | stale_ack;

    vram_blit_copy #(.COUNT_W(16)) dut (
        .clk            (clk),
        .reset_ni       (reset_ni),
        .start_i        (start_i),
        .mode_i         (mode_i),
        .src_addr_i     (src_addr_i),
        .dst_addr_i     (dst_addr_i),
        .count_i        (count_i),
        .fill_data_i    (fill_data_i),
        .wr_mask_i      (wr_mask_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .blit_sel_o     (blit_sel_o),
        .blit_wr_o      (blit_wr_o),
        .blit_wr_mask_o (blit_wr_mask_o),
        .blit_addr_o    (blit_addr_o),
        .blit_data_o    (blit_data_o),
        .blit_ack_i     (blit_ack_i),
        .vram_data_i    (vram_data_i)
    );

    function automatic word_t merge(input word_t old_w, input word_t new_w, input logic [3:0] m);
        word_t r;
        r = old_w;
        for (int i = 0; i < 4; i++)
            if (m[i]) r[4*i +: 4] = new_w[4*i +: 4];
        return r;
    endfunction

    // Arbiter + VRAM model: grant on a free cycle, ack the cycle after grant,
    // never re-grant while ack is high.
    always @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            arb_ack     <= 1'b0;
            vram_data_i <= '0;
        end else begin
            arb_ack <= 1'b0;
            if (blit_sel_o && !arb_ack && !vgen_sel) begin
                arb_ack <= 1'b1;
                grants  <= grants + 1;
                if (blit_wr_o)
                    mem[blit_addr_o] <= merge(mem[blit_addr_o], blit_data_o, blit_wr_mask_o);
                else
                    vram_data_i <= mem[blit_addr_o];
            end
        end
    end

    // Called at a falling edge; leaves the bench one falling edge later.
    task automatic pulse_start(input logic m, input addr_t s, input addr_t d,
                               input logic [15:0] n, input word_t f, input logic [3:0] k);
        mode_i = m; src_addr_i = s; dst_addr_i = d; count_i = n;
        fill_data_i = f; wr_mask_i = k; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    // Counts falling edges until done_o (bounded); c0 is the cycle index on entry.
    task automatic wait_done(input int c0, output int cycles, output int busy_c, output int sel_c);
        cycles = c0; busy_c = 0; sel_c = 0;
        while (!done_o && cycles < 200) begin
            if (busy_o) busy_c++;
            if (blit_sel_o) sel_c++;
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        reset_ni = 1'b0; start_i = 1'b0; mode_i = 1'b0; src_addr_i = '0; dst_addr_i = '0;
        count_i = '0; fill_data_i = '0; wr_mask_i = '0; vgen_sel = 1'b0; stale_ack = 1'b0;
        grants = 0;
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        mem[16'h0200] = 16'h1111; mem[16'h0201] = 16'h2222; mem[16'h0202] = 16'h3333;
        mem[16'h0400] = 16'hBEEF; mem[16'h0401] = 16'hCAFE; mem[16'h0402] = 16'hF00D;
        mem[16'hFFFD] = 16'h1234; mem[16'hFFFE] = 16'h1234; mem[16'hFFFF] = 16'h1234;
        mem[16'h0000] = 16'h1234; mem[16'h0001] = 16'h1234;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy_o, done_o, blit_sel_o, blit_wr_o, blit_wr_mask_o, blit_addr_o, blit_data_o} !== 40'd0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b done=%b sel=%b wr=%b mask=%h addr=%h data=%h want all 0",
                     busy_o, done_o, blit_sel_o, blit_wr_o, blit_wr_mask_o, blit_addr_o, blit_data_o);
        end
        reset_ni = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fill();
        int cyc, bc, sc;
        pulse_start(1'b0, 16'h0000, 16'h0100, 16'd4, 16'hA5A5, 4'hF);
        checks++;
        if ({busy_o, blit_sel_o, blit_wr_o, blit_addr_o, blit_data_o, blit_wr_mask_o} !== {1'b1, 1'b1, 1'b1, 16'h0100, 16'hA5A5, 4'hF}) begin
            errors++;
            $display("FAIL fill_first_req got busy=%b sel=%b wr=%b addr=%h data=%h mask=%h want 1 1 1 0100 a5a5 f",
                     busy_o, blit_sel_o, blit_wr_o, blit_addr_o, blit_data_o, blit_wr_mask_o);
        end
        wait_done(1, cyc, bc, sc);
        checks++;
        if (cyc !== 9 || bc !== 8) begin
            errors++;
            $display("FAIL fill_timing got done_cycle=%0d busy_cycles=%0d want 9 8", cyc, bc);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem[16'h0100 + i] !== 16'hA5A5) begin
                errors++;
                $display("FAIL fill_word%0d got %h want a5a5", i, mem[16'h0100 + i]);
            end
        end
        checks++;
        if (mem[16'h0104] !== 16'h0000) begin
            errors++;
            $display("FAIL fill_overrun got %h want 0000", mem[16'h0104]);
        end
        @(negedge clk);
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || blit_sel_o !== 1'b0) begin
            errors++;
            $display("FAIL fill_done_pulse got done=%b busy=%b sel=%b want 0 0 0", done_o, busy_o, blit_sel_o);
        end
    endtask

    task automatic test_copy();
        int cyc, bc, sc, g0;
        g0 = grants;
        pulse_start(1'b1, 16'h0200, 16'h0300, 16'd3, 16'h0000, 4'hF);
        checks++;
        if (blit_sel_o !== 1'b1 || blit_wr_o !== 1'b0 || blit_addr_o !== 16'h0200) begin
            errors++;
            $display("FAIL copy_first_read got sel=%b wr=%b addr=%h want 1 0 0200", blit_sel_o, blit_wr_o, blit_addr_o);
        end
        wait_done(1, cyc, bc, sc);
        checks++;
        if (cyc !== 13 || sc !== 12 || grants - g0 !== 6) begin
            errors++;
            $display("FAIL copy_timing got done_cycle=%0d sel_cycles=%0d accesses=%0d want 13 12 6", cyc, sc, grants - g0);
        end
        checks++;
        if ({mem[16'h0300], mem[16'h0301], mem[16'h0302]} !== 48'h1111_2222_3333) begin
            errors++;
            $display("FAIL copy_data got %h %h %h want 1111 2222 3333", mem[16'h0300], mem[16'h0301], mem[16'h0302]);
        end
        @(negedge clk);
    endtask

    task automatic test_copy_contended();
        int cyc, bc, sc, g0;
        g0 = grants;
        pulse_start(1'b1, 16'h0400, 16'h0500, 16'd3, 16'h0000, 4'hF);
        @(negedge clk);
        @(negedge clk);
        vgen_sel = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({blit_sel_o, blit_wr_o, blit_addr_o, blit_data_o} !== {1'b1, 1'b1, 16'h0500, 16'hBEEF}) begin
                errors++;
                $display("FAIL stall_hold%0d got sel=%b wr=%b addr=%h data=%h want 1 1 0500 beef",
                         i, blit_sel_o, blit_wr_o, blit_addr_o, blit_data_o);
            end
        end
        vgen_sel = 1'b0;
        wait_done(8, cyc, bc, sc);
        checks++;
        if (cyc !== 18 || grants - g0 !== 6) begin
            errors++;
            $display("FAIL stall_timing got done_cycle=%0d accesses=%0d want 18 6", cyc, grants - g0);
        end
        checks++;
        if ({mem[16'h0500], mem[16'h0501], mem[16'h0502], mem[16'h0503]} !== 64'hBEEF_CAFE_F00D_0000) begin
            errors++;
            $display("FAIL stall_data got %h %h %h %h want beef cafe f00d 0000",
                     mem[16'h0500], mem[16'h0501], mem[16'h0502], mem[16'h0503]);
        end
        @(negedge clk);
    endtask

    task automatic test_fill_wrap();
        int cyc, bc, sc;
        pulse_start(1'b0, 16'h0000, 16'hFFFE, 16'd3, 16'hABCD, 4'h3);
        wait_done(1, cyc, bc, sc);
        checks++;
        if (cyc !== 7) begin
            errors++;
            $display("FAIL wrap_timing got done_cycle=%0d want 7", cyc);
        end
        checks++;
        if ({mem[16'hFFFD], mem[16'hFFFE], mem[16'hFFFF], mem[16'h0000], mem[16'h0001]} !== 80'h1234_12CD_12CD_12CD_1234) begin
            errors++;
            $display("FAIL wrap_data got %h %h %h %h %h want 1234 12cd 12cd 12cd 1234",
                     mem[16'hFFFD], mem[16'hFFFE], mem[16'hFFFF], mem[16'h0000], mem[16'h0001]);
        end
        @(negedge clk);
    endtask

    task automatic test_zero_count();
        int g0;
        g0 = grants;
        pulse_start(1'b0, 16'h0000, 16'h0700, 16'd0, 16'hFFFF, 4'hF);
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || blit_sel_o !== 1'b0) begin
            errors++;
            $display("FAIL zero_done got done=%b busy=%b sel=%b want 1 0 0", done_o, busy_o, blit_sel_o);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (grants - g0 !== 0 || done_o !== 1'b0 || mem[16'h0700] !== 16'h0000) begin
            errors++;
            $display("FAIL zero_noaccess got accesses=%0d done=%b mem=%h want 0 0 0000", grants - g0, done_o, mem[16'h0700]);
        end
    endtask

    task automatic test_start_ignored();
        int cyc, bc, sc, g0;
        g0 = grants;
        pulse_start(1'b0, 16'h0000, 16'h0600, 16'd4, 16'h5555, 4'hF);
        @(negedge clk);
        pulse_start(1'b1, 16'h0200, 16'h0800, 16'd2, 16'hFFFF, 4'h0);
        wait_done(3, cyc, bc, sc);
        checks++;
        if (cyc !== 9 || grants - g0 !== 4) begin
            errors++;
            $display("FAIL restart_timing got done_cycle=%0d accesses=%0d want 9 4", cyc, grants - g0);
        end
        checks++;
        if ({mem[16'h0600], mem[16'h0601], mem[16'h0602], mem[16'h0603], mem[16'h0800]} !== 80'h5555_5555_5555_5555_0000) begin
            errors++;
            $display("FAIL restart_data got %h %h %h %h %h want 5555 5555 5555 5555 0000",
                     mem[16'h0600], mem[16'h0601], mem[16'h0602], mem[16'h0603], mem[16'h0800]);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_copy();
        pulse_start(1'b1, 16'h0200, 16'h0900, 16'd3, 16'h0000, 4'hF);
        repeat (3) @(negedge clk);
        reset_ni = 1'b0;
        #1;
        checks++;
        if (blit_sel_o !== 1'b0 || busy_o !== 1'b0 || blit_addr_o !== 16'h0000 || blit_data_o !== 16'h0000) begin
            errors++;
            $display("FAIL midreset_outputs got sel=%b busy=%b addr=%h data=%h want 0 0 0000 0000",
                     blit_sel_o, busy_o, blit_addr_o, blit_data_o);
        end
        @(negedge clk);
        reset_ni = 1'b1;
        stale_ack = 1'b1;
        @(negedge clk);
        stale_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({busy_o, done_o, blit_sel_o, blit_wr_o} !== 4'b0000) begin
                errors++;
                $display("FAIL stale_ack%0d got busy=%b done=%b sel=%b wr=%b want 0 0 0 0",
                         i, busy_o, done_o, blit_sel_o, blit_wr_o);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_copy();
        test_copy_contended();
        test_fill_wrap();
        test_zero_count();
        test_start_ignored();
        test_reset_mid_copy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_vram_blit_copy
`default_nettype wire
